fill_rect: RTL and testbench



---
 rtl/fill_pkg.sv | 35 +++
 rtl/fill_rect_if.sv | 28 ++
 rtl/fill_xy_counter.sv | 63 ++++++
 rtl/fill_rect.sv | 245 ++++++++++++++++++++++++
 tb/tb_fill_rect.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fill_pkg.sv
`default_nettype none
// ============================================================================
// fill_pkg : opcodes, FSM states and header word indices for fill_rect
// Rev 1.0
// ============================================================================
package fill_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        FIN
    } state_t;

    typedef enum logic [3:0] {
        W_CASET,
        W_X0_HI,
        W_X0_LO,
        W_X1_HI,
        W_X1_LO,
        W_PASET,
        W_Y0_HI,
        W_Y0_LO,
        W_Y1_HI,
        W_Y1_LO,
        W_RAMWR
    } word_t;

endpackage
`default_nettype wire

// File: rtl/fill_rect_if.sv
`default_nettype none
// ============================================================================
// fill_rect_if : word handshake between a draw block and the LCD bus writer
// Rev 1.0
// ============================================================================
interface fill_rect_if #(
    parameter int COLOR_W = 16
);
    logic               start;
    logic               commanddata;
    logic [COLOR_W-1:0] valueout;
    logic               status_execution;

    modport master (
        output start,
        output commanddata,
        output valueout,
        input  status_execution
    );

    modport slave (
        input  start,
        input  commanddata,
        input  valueout,
        output status_execution
    );
endinterface
`default_nettype wire

// File: rtl/fill_xy_counter.sv
`default_nettype none
// ============================================================================
// fill_xy_counter : nested column/row walk over an inclusive rectangle
// Rev 1.0
// ============================================================================
module fill_xy_counter #(
    parameter int XW = 9
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             load,
    input  wire             advance,
    input  wire  [XW-1:0]   x0,
    input  wire  [XW-1:0]   x1,
    input  wire  [XW-1:0]   y0,
    input  wire  [XW-1:0]   y1,
    output logic [2*XW-1:0] col,
    output logic [2*XW-1:0] row,
    output logic            last
);
    localparam int CW = 2 * XW;

    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_x0;
    logic [CW-1:0] r_x1;
    logic [CW-1:0] r_y1;
    logic          w_col_end;
    logic          w_row_end;

    assign w_col_end = (r_col == r_x1);
    assign w_row_end = (r_row == r_y1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_x0  <= '0;
            r_x1  <= '0;
            r_y1  <= '0;
        end else if (load) begin
            r_col <= CW'(x0);
            r_row <= CW'(y0);
            r_x0  <= CW'(x0);
            r_x1  <= CW'(x1);
            r_y1  <= CW'(y1);
        end else if (advance) begin
            // column wraps back to x0 and carries into the row
            if (w_col_end) begin
                r_col <= r_x0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign last = w_col_end && w_row_end;

endmodule
`default_nettype wire

// File: rtl/fill_rect.sv
`default_nettype none
// ============================================================================
// fill_rect : fills rectangle (x0,y0)-(x1,y1) via CASET/PASET/RAMWR + pixels.
// Optional FILL_RECT_CHECKER_EN adds a two-colour checkerboard.   Rev 1.0
// ============================================================================
module fill_rect #(
    parameter int         XW        = 9,
    parameter int         COLOR_W   = 16,
    parameter logic [7:0] CMD_CASET = fill_pkg::CMD_CASET,
    parameter logic [7:0] CMD_PASET = fill_pkg::CMD_PASET,
    parameter logic [7:0] CMD_RAMWR = fill_pkg::CMD_RAMWR
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                go,
    input  wire  [XW-1:0]      x0,
    input  wire  [XW-1:0]      x1,
    input  wire  [XW-1:0]      y0,
    input  wire  [XW-1:0]      y1,
    input  wire  [COLOR_W-1:0] color,
`ifdef FILL_RECT_CHECKER_EN
    input  wire                checker_on,
    input  wire  [COLOR_W-1:0] color2,
`endif
    output logic               busy,
    output logic               done,
    output logic               err,
    fill_rect_if.master        wr
);
    import fill_pkg::*;

    localparam int CW = 2 * XW;

    state_t             r_state;
    word_t              r_word;
    logic               r_pix;
    logic               r_hold;
    logic               r_last;
    logic [XW-1:0]      r_x0;
    logic [XW-1:0]      r_x1;
    logic [XW-1:0]      r_y0;
    logic [XW-1:0]      r_y1;
    logic [COLOR_W-1:0] r_color;
    logic [COLOR_W-1:0] r_val;
    logic               r_cd;
    logic               r_start;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [CW-1:0]      w_col;
    logic [CW-1:0]      w_row;
    logic               w_last;
    logic               w_bad;
    logic               w_accept;
    logic               w_advance;
    logic [COLOR_W-1:0] w_pix_color;
    logic [15:0]        w_x0w;
    logic [15:0]        w_x1w;
    logic [15:0]        w_y0w;
    logic [15:0]        w_y1w;
    word_t              w_nxt;

    assign w_bad     = (x0 > x1) || (y0 > y1);
    assign w_accept  = (r_state == IDLE) && go && !w_bad;
    // step after each pixel is issued so the counter already names the next one
    assign w_advance = (r_state == ISSUE) && r_pix && !w_last;
    assign w_nxt     = word_t'(r_word + 4'd1);

    assign w_x0w = 16'(r_x0);
    assign w_x1w = 16'(r_x1);
    assign w_y0w = 16'(r_y0);
    assign w_y1w = 16'(r_y1);

    fill_xy_counter #(
        .XW      (XW)
    ) u_xy (
        .clk     (clk),
        .rst     (rst),
        .load    (w_accept),
        .advance (w_advance),
        .x0      (x0),
        .x1      (x1),
        .y0      (y0),
        .y1      (y1),
        .col     (w_col),
        .row     (w_row),
        .last    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_color <= '0;
        end else if (w_accept) begin
            r_x0    <= x0;
            r_x1    <= x1;
            r_y0    <= y0;
            r_y1    <= y1;
            r_color <= color;
        end
    end

`ifdef FILL_RECT_CHECKER_EN
    logic               r_chk;
    logic [COLOR_W-1:0] r_color2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk    <= 1'b0;
            r_color2 <= '0;
        end else if (w_accept) begin
            r_chk    <= checker_on;
            r_color2 <= color2;
        end
    end

    assign w_pix_color = (r_chk && (w_col[0] ^ w_row[0])) ? r_color2 : r_color;
`else
    assign w_pix_color = r_color;
`endif

    logic w_unused_pos;
    assign w_unused_pos = ^{w_col, w_row};

    // {commanddata, valueout} for one of the 11 header words
    function automatic logic [COLOR_W:0] hdr_word(input word_t w);
        case (w)
            W_CASET: return {1'b0, COLOR_W'(CMD_CASET)};
            W_X0_HI: return {1'b1, COLOR_W'(w_x0w[15:8])};
            W_X0_LO: return {1'b1, COLOR_W'(w_x0w[7:0])};
            W_X1_HI: return {1'b1, COLOR_W'(w_x1w[15:8])};
            W_X1_LO: return {1'b1, COLOR_W'(w_x1w[7:0])};
            W_PASET: return {1'b0, COLOR_W'(CMD_PASET)};
            W_Y0_HI: return {1'b1, COLOR_W'(w_y0w[15:8])};
            W_Y0_LO: return {1'b1, COLOR_W'(w_y0w[7:0])};
            W_Y1_HI: return {1'b1, COLOR_W'(w_y1w[15:8])};
            W_Y1_LO: return {1'b1, COLOR_W'(w_y1w[7:0])};
            default: return {1'b0, COLOR_W'(CMD_RAMWR)};
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= W_CASET;
            r_pix   <= 1'b0;
            r_hold  <= 1'b0;
            r_last  <= 1'b0;
            r_start <= 1'b0;
            r_cd    <= 1'b0;
            r_val   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (go) begin
                        if (w_bad) begin
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_busy <= 1'b1;
                            r_word <= W_CASET;
                            r_pix  <= 1'b0;
                            r_last <= 1'b0;
                            if (!wr.status_execution) begin
                                r_hold          <= 1'b0;
                                r_start         <= 1'b1;
                                {r_cd, r_val}   <= hdr_word(W_CASET);
                                r_state         <= ISSUE;
                            end else begin
                                // writer still busy: park until it frees up
                                r_hold  <= 1'b1;
                                r_state <= WAIT_DONE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (r_pix && w_last) begin
                        r_last <= 1'b1;
                    end
                    r_state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (wr.status_execution) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!wr.status_execution) begin
                        if (r_hold) begin
                            r_hold        <= 1'b0;
                            r_start       <= 1'b1;
                            {r_cd, r_val} <= hdr_word(W_CASET);
                            r_state       <= ISSUE;
                        end else if (r_pix || (r_word == W_RAMWR)) begin
                            if (r_last) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_err   <= 1'b0;
                                r_state <= FIN;
                            end else begin
                                r_pix   <= 1'b1;
                                r_start <= 1'b1;
                                r_cd    <= 1'b1;
                                r_val   <= w_pix_color;
                                r_state <= ISSUE;
                            end
                        end else begin
                            r_word        <= w_nxt;
                            r_start       <= 1'b1;
                            {r_cd, r_val} <= hdr_word(w_nxt);
                            r_state       <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr.start       = r_start;
    assign wr.commanddata = r_cd;
    assign wr.valueout    = r_val;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fill_rect.sv
`default_nettype none
// ============================================================================
// tb_fill_rect : directed scoreboard bench for fill_rect with a model writer
// Rev 1.0
// ============================================================================
module tb_fill_rect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go  = 1'b0;
    logic [8:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic [15:0] color = '0;
`ifdef FILL_RECT_CHECKER_EN
    logic        checker_on = 1'b0;
    logic [15:0] color2 = '0;
`endif
    logic        busy, done, err;

    fill_rect_if #(.COLOR_W(16)) bus ();

    fill_rect dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .color      (color),
`ifdef FILL_RECT_CHECKER_EN
        .checker_on (checker_on),
        .color2     (color2),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wr         (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_starts = 0;
    int          n_dones  = 0;
    logic [16:0] exp_q[$];
    logic [16:0] last_word = '0;

    // writer model: raises status ack_dly cycles after start, holds hold_len
    int   ack_dly = 1, hold_len = 1;
    int   w_timer = 0, w_hold = 0;
    logic w_stat = 1'b0;
    logic force_busy = 1'b0;

    assign bus.status_execution = w_stat | force_busy;

    always @(negedge clk) begin
        if (rst) begin
            w_timer = 0; w_hold = 0; w_stat = 1'b0;
        end else if (bus.start) begin
            w_timer = ack_dly;
        end else if (w_timer > 0) begin
            w_timer--;
            if (w_timer == 0) begin w_stat = 1'b1; w_hold = hold_len; end
        end else if (w_stat) begin
            w_hold--;
            if (w_hold <= 0) w_stat = 1'b0;
        end
    end

    // output monitor: scoreboard pop on start, hold check otherwise
    always @(negedge clk) begin
        if (rst) begin
            last_word = '0;
        end else begin
            if (done === 1'b1) n_dones++;
            if (bus.start === 1'b1) begin
                n_starts++;
                last_word = {bus.commanddata, bus.valueout};
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_start got=%h required=none", last_word);
                end
                if (exp_q.size() != 0) begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    n_checks++;
                    assert (last_word === e) else begin
                        n_fail++;
                        $error("FAIL word%0d got=%h required=%h", n_starts, last_word, e);
                    end
                end
            end else if (busy === 1'b1) begin
                n_checks++;
                assert ({bus.commanddata, bus.valueout} === last_word) else begin
                    n_fail++;
                    $error("FAIL hold got=%h required=%h", {bus.commanddata, bus.valueout}, last_word);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h required=%0h", tag, got, exp);
        end
    endtask

    task automatic push_fill(input logic [8:0] a0, a1, b0, b1,
                             input logic [15:0] ca, cb, input logic chkm);
        logic [15:0] v;
        exp_q.push_back({1'b0, 16'h002A});
        v = {7'd0, a0}; exp_q.push_back({1'b1, 8'h00, v[15:8]}); exp_q.push_back({1'b1, 8'h00, v[7:0]});
        v = {7'd0, a1}; exp_q.push_back({1'b1, 8'h00, v[15:8]}); exp_q.push_back({1'b1, 8'h00, v[7:0]});
        exp_q.push_back({1'b0, 16'h002B});
        v = {7'd0, b0}; exp_q.push_back({1'b1, 8'h00, v[15:8]}); exp_q.push_back({1'b1, 8'h00, v[7:0]});
        v = {7'd0, b1}; exp_q.push_back({1'b1, 8'h00, v[15:8]}); exp_q.push_back({1'b1, 8'h00, v[7:0]});
        exp_q.push_back({1'b0, 16'h002C});
        for (int r = int'(b0); r <= int'(b1); r++)
            for (int c = int'(a0); c <= int'(a1); c++)
                exp_q.push_back({1'b1, (chkm && (((r ^ c) & 1) != 0)) ? cb : ca});
    endtask

    task automatic do_go(input logic [8:0] a0, a1, b0, b1, input logic [15:0] c);
        @(negedge clk);
        x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        x0 = '1; x1 = '0; color = 16'hDEAD;
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic exp_err);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk); #1; k++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int s0, k, d0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_cd",    32'(bus.commanddata), 0);
        chk("rst_val",   32'(bus.valueout), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(err), 0);
        rst = 1'b0;

        // 3x2 rectangle, slow writer
        ack_dly = 2; hold_len = 1;
        push_fill(9'd10, 9'd12, 9'd5, 9'd6, 16'hF800, 16'h0, 1'b0);
        s0 = n_starts;
        do_go(9'd10, 9'd12, 9'd5, 9'd6, 16'hF800);
        chk("t1_busy", 32'(busy), 1);
        wait_done("t1", 2000, 1'b0);
        chk("t1_starts", 32'(n_starts - s0), 17);
        chk("t1_qempty", 32'(exp_q.size()), 0);
        @(negedge clk); #1;
        chk("t1_done_pulse", 32'(done), 0);

        // single pixel, go held on the done cycle must be ignored
        ack_dly = 1; hold_len = 1;
        push_fill(9'd0, 9'd0, 9'd0, 9'd0, 16'h1234, 16'h0, 1'b0);
        s0 = n_starts;
        do_go(9'd0, 9'd0, 9'd0, 9'd0, 16'h1234);
        chk("t2_busy", 32'(busy), 1);
        wait_done("t2", 500, 1'b0);
        chk("t2_starts", 32'(n_starts - s0), 12);
        x0 = 9'd1; x1 = 9'd2; y0 = 9'd1; y1 = 9'd1; color = 16'h7777; go = 1'b1;
        @(negedge clk); go = 1'b0; #1;
        chk("t2_done_pulse", 32'(done), 0);
        repeat (5) @(negedge clk);
        #1;
        chk("t2_go_on_done_starts", 32'(n_starts - s0), 12);
        chk("t2_go_on_done_busy", 32'(busy), 0);

        // invalid requests
        s0 = n_starts;
        do_go(9'd20, 9'd10, 9'd0, 9'd0, 16'h0001);
        wait_done("t3", 0, 1'b1);
        @(negedge clk); #1;
        chk("t3_done_pulse", 32'(done), 0);
        do_go(9'd0, 9'd5, 9'd9, 9'd8, 16'h0002);
        wait_done("t4", 0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t34_no_start", 32'(n_starts - s0), 0);

        // writer busy at go: pre-issue hold
        force_busy = 1'b1;
        push_fill(9'd3, 9'd4, 9'd7, 9'd7, 16'h0F0F, 16'h0, 1'b0);
        s0 = n_starts;
        do_go(9'd3, 9'd4, 9'd7, 9'd7, 16'h0F0F);
        repeat (5) @(negedge clk);
        #1;
        chk("t5_held_no_start", 32'(n_starts - s0), 0);
        chk("t5_held_busy", 32'(busy), 1);
        force_busy = 1'b0;
        wait_done("t5", 500, 1'b0);
        chk("t5_starts", 32'(n_starts - s0), 13);

        // large fill, 1-cycle writer
        push_fill(9'd0, 9'd239, 9'd0, 9'd39, 16'h07E0, 16'h0, 1'b0);
        s0 = n_starts;
        do_go(9'd0, 9'd239, 9'd0, 9'd39, 16'h07E0);
        wait_done("t6", 40000, 1'b0);
        chk("t6_starts", 32'(n_starts - s0), 9611);
        chk("t6_qempty", 32'(exp_q.size()), 0);

        // asynchronous reset during pixel 3 of a 2x2 fill
        push_fill(9'd2, 9'd3, 9'd2, 9'd3, 16'hAAAA, 16'h0, 1'b0);
        s0 = n_starts;
        d0 = n_dones;
        do_go(9'd2, 9'd3, 9'd2, 9'd3, 16'hAAAA);
        k = 0;
        while ((n_starts - s0) < 14 && k < 300) begin
            @(negedge clk); #1; k++;
        end
        chk("t7_reached_pixel3", 32'(n_starts - s0), 14);
        #1 rst = 1'b1;
        #1;
        chk("t7_rst_start", 32'(bus.start), 0);
        chk("t7_rst_val",   32'(bus.valueout), 0);
        chk("t7_rst_cd",    32'(bus.commanddata), 0);
        chk("t7_rst_busy",  32'(busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("t7_no_done", 32'(n_dones - d0), 0);
        chk("t7_no_start", 32'(n_starts - s0), 14);
        push_fill(9'd2, 9'd3, 9'd2, 9'd3, 16'h5555, 16'h0, 1'b0);
        s0 = n_starts;
        do_go(9'd2, 9'd3, 9'd2, 9'd3, 16'h5555);
        wait_done("t7b", 500, 1'b0);
        chk("t7b_starts", 32'(n_starts - s0), 15);

`ifdef FILL_RECT_CHECKER_EN
        checker_on = 1'b1; color2 = 16'hBBBB;
        push_fill(9'd0, 9'd1, 9'd0, 9'd1, 16'hAAAA, 16'hBBBB, 1'b1);
        do_go(9'd0, 9'd1, 9'd0, 9'd1, 16'hAAAA);
        wait_done("t8", 500, 1'b0);
        checker_on = 1'b0;
        push_fill(9'd0, 9'd1, 9'd0, 9'd1, 16'hAAAA, 16'hBBBB, 1'b0);
        do_go(9'd0, 9'd1, 9'd0, 9'd1, 16'hAAAA);
        wait_done("t9", 500, 1'b0);
`endif

        repeat (2) @(negedge clk);
        chk("final_qempty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
